// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 receive definitions: data types, FSM states, header layout.
// Imported by the packet decoder and the header ECC block.
package mipi_csi_pkg;

  localparam int WC_W  = 16;
  localparam int CNT_W = 15;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [7:0]      ecc;
    logic [WC_W-1:0] wc;
    logic [1:0]      vc;
    logic [5:0]      dt;
  } hdr_t;

  // Byte count rounded up to whole 32-bit words; 17-bit sum avoids wrap.
  function automatic logic [CNT_W-1:0] wc_to_words(
    input logic [WC_W-1:0] wc
  );
    logic [WC_W:0] s;
    s = {1'b0, wc} + 17'd3;
    return s[WC_W:2];
  endfunction

endpackage

// File: rtl/mipi_csi_header_ecc.sv
// Combinational 6-bit CSI-2 packet header ECC over DataID and word count.
// Used by the decoder only when MIPI_RX_HEADER_ECC_CHECK_EN is defined.
module mipi_csi_header_ecc
  import mipi_csi_pkg::*;
(
  input  logic [23:0] hdr_i,
  output logic [5:0]  ecc_o
);

  localparam logic [23:0] M0 = 24'hF12CB7;
  localparam logic [23:0] M1 = 24'hF2555B;
  localparam logic [23:0] M2 = 24'h749A6D;
  localparam logic [23:0] M3 = 24'hB8E38E;
  localparam logic [23:0] M4 = 24'hDF03F0;
  localparam logic [23:0] M5 = 24'hEFFC00;

  assign ecc_o[0] = ^(hdr_i & M0);
  assign ecc_o[1] = ^(hdr_i & M1);
  assign ecc_o[2] = ^(hdr_i & M2);
  assign ecc_o[3] = ^(hdr_i & M3);
  assign ecc_o[4] = ^(hdr_i & M4);
  assign ecc_o[5] = ^(hdr_i & M5);

endmodule

// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 packet decoder: header parse, VC/DT filter, RAW10/12 payload gate.
// Optional header ECC check enabled by MIPI_RX_HEADER_ECC_CHECK_EN.
module mipi_rx_packet_decoder
  import mipi_csi_pkg::*;
#(
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        output_valid_o,
  output logic [31:0] output_o,
  output logic [2:0]  packet_type_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        pkt_error_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [31:0]      out_q, out_d;
  logic [2:0]       type_q, type_d;
  logic             fs_q, fs_d;
  logic             fe_q, fe_d;
  logic             err_q, err_d;

  hdr_t hdr;
  logic vc_ok;
  logic is_long;
  logic hdr_ok;

  assign hdr     = hdr_t'(data_i);
  assign vc_ok   = hdr.vc == VIRTUAL_CHANNEL;
  assign is_long = (hdr.dt == DT_RAW10) ||
                   (hdr.dt == DT_RAW12);

`ifdef MIPI_RX_HEADER_ECC_CHECK_EN
  logic [5:0] ecc_calc;

  mipi_csi_header_ecc u_ecc (
    .hdr_i (data_i[23:0]),
    .ecc_o (ecc_calc)
  );

  assign hdr_ok = hdr.ecc == {2'b00, ecc_calc};
`else
  logic unused_ecc;

  assign unused_ecc = ^hdr.ecc;
  assign hdr_ok     = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    out_d   = out_q;
    type_d  = type_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // IDLE is only reached after a low cycle, so valid here is a header
        if (data_valid_i) begin
          state_d = ST_DRAIN;
          unique case (1'b1)
            !hdr_ok: err_d = 1'b1;
            hdr_ok && !vc_ok: ;
            vc_ok && hdr_ok && (hdr.dt == DT_FS):
              fs_d = 1'b1;
            vc_ok && hdr_ok && (hdr.dt == DT_FE):
              fe_d = 1'b1;
            vc_ok && hdr_ok && is_long && (hdr.wc != '0): begin
              type_d  = hdr.dt[2:0];
              cnt_d   = wc_to_words(hdr.wc);
              state_d = ST_PAYLOAD;
            end
            default: ;
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (data_valid_i) begin
          ov_d  = 1'b1;
          out_d = data_i;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 15'd1) begin
            state_d = ST_DRAIN;
          end
        end else begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!data_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      out_q   <= '0;
      type_q  <= '0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      out_q   <= out_d;
      type_q  <= type_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      err_q   <= err_d;
    end
  end

  assign output_valid_o = ov_q;
  assign output_o       = out_q;
  assign packet_type_o  = type_q;
  assign frame_start_o  = fs_q;
  assign frame_end_o    = fe_q;
  assign pkt_error_o    = err_q;

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// Scoreboard bench for mipi_rx_packet_decoder: stimulus pushes expected
// words/pulses with their sample edge, a monitor pops and compares.
module tb_mipi_rx_packet_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data = '0;
  logic        ov;
  logic [31:0] dout;
  logic [2:0]  ptype;
  logic        fs, fe, err;

  mipi_rx_packet_decoder #(
    .VIRTUAL_CHANNEL (2'd0)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .data_valid_i   (valid),
    .data_i         (data),
    .output_valid_o (ov),
    .output_o       (dout),
    .packet_type_o  (ptype),
    .frame_start_o  (fs),
    .frame_end_o    (fe),
    .pkt_error_o    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  t;
    int          e;
  } wexp_t;

  typedef struct {
    int k;
    int e;
  } pexp_t;

  wexp_t wq[$];
  pexp_t pq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int seq = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Header ECC parity masks, one per ECC bit (D0 = LSB of DataID).
  function automatic logic [7:0] ecc24(input logic [23:0] h);
    logic [23:0] m [6];
    logic [7:0]  r;
    m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
    m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
    r = '0;
    for (int i = 0; i < 6; i++) r[i] = ^(h & m[i]);
    return r;
  endfunction

  function automatic logic [31:0] mkhdr(input logic [1:0] vc,
    input logic [5:0] dt, input logic [15:0] wc);
    logic [23:0] h;
    h = {wc, vc, dt};
    return {ecc24(h), h};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d,
                       output int e);
    @(negedge clk);
    valid = v;
    data  = d;
    e     = cyc + 1;
  endtask

  // pk: 0 none, 1 FS, 2 FE, 3 error at header edge
  task automatic send(input logic [31:0] hdr, input int nw,
    input int nexp, input logic [2:0] typ, input int pk,
    input bit trunc);
    int e;
    logic [31:0] w;
    drive(1'b1, hdr, e);
    if (pk != 0) pq.push_back('{pk, e});
    for (int k = 0; k < nw; k++) begin
      seq++;
      w = 32'hC0DE_0000 + seq;
      drive(1'b1, w, e);
      if (k < nexp) wq.push_back('{w, typ, e});
    end
    drive(1'b0, 32'h0, e);
    if (trunc) pq.push_back('{3, e});
    drive(1'b0, 32'h0, e);
  endtask

  // Monitor
  logic       prev_ov = 1'b0;
  logic [2:0] prev_t = '0;

  task automatic pulse(input int k, input int e);
    pexp_t p;
    if (pq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL pulse_unexp: got kind %0d at %0d expected none",
               k, e);
    end else begin
      p = pq.pop_front();
      chk("pulse_kind", k, p.k);
      chk("pulse_edge", e, p.e);
    end
  endtask

  initial forever begin
    wexp_t w;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      prev_ov = 1'b0;
      prev_t  = '0;
    end else begin
      if (ov) begin
        if (wq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_unexp: got %h expected none", dout);
        end else begin
          w = wq.pop_front();
          chk("out_data", dout, w.d);
          chk("out_type", {29'd0, ptype}, {29'd0, w.t});
          chk("out_edge", cyc, w.e);
          if (!prev_ov) chk("type_ahead", {29'd0, prev_t}, {29'd0, w.t});
        end
      end
      if (fs)  pulse(1, cyc);
      if (fe)  pulse(2, cyc);
      if (err) pulse(3, cyc);
      prev_ov = ov;
      prev_t  = ptype;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    logic [31:0] h;
    repeat (3) @(negedge clk);
    chk("rst_ov", ov, 0);
    chk("rst_out", dout, 0);
    chk("rst_type", ptype, 0);
    chk("rst_pulses", {fs, fe, err}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // RAW10 WC=50 -> 13 words of 14
    send(mkhdr(2'd0, 6'h2B, 16'd50), 14, 13, 3'd3, 0, 1'b0);
    // VC=1 packet rejected
    send(mkhdr(2'd1, 6'h2C, 16'd6), 3, 0, 3'd0, 0, 1'b0);
    chk("vc_type_hold", ptype, 3);
    // Frame start / end
    send(mkhdr(2'd0, 6'h00, 16'd1), 0, 0, 3'd0, 1, 1'b0);
    send(mkhdr(2'd0, 6'h01, 16'd2), 0, 0, 3'd0, 2, 1'b0);
    chk("fsfe_type_hold", ptype, 3);
    // Truncated RAW12 WC=40 after 4 words
    send(mkhdr(2'd0, 6'h2C, 16'd40), 4, 4, 3'd4, 0, 1'b1);
    send(mkhdr(2'd0, 6'h2B, 16'd8), 3, 2, 3'd3, 0, 1'b0);
    // WC=0 and non-RAW type are dropped
    send(mkhdr(2'd0, 6'h2C, 16'd0), 2, 0, 3'd0, 0, 1'b0);
    chk("wc0_type_hold", ptype, 3);
    send(mkhdr(2'd0, 6'h2A, 16'd8), 3, 0, 3'd0, 0, 1'b0);
    // Word count rounding boundaries
    send(mkhdr(2'd0, 6'h2C, 16'd1), 2, 1, 3'd4, 0, 1'b0);
    send(mkhdr(2'd0, 6'h2B, 16'd4), 2, 1, 3'd3, 0, 1'b0);
    send(mkhdr(2'd0, 6'h2B, 16'd5), 3, 2, 3'd3, 0, 1'b0);
    // Corrupted ECC bit 0 on a RAW12 header
    h = mkhdr(2'd0, 6'h2C, 16'd8) ^ 32'h0100_0000;
`ifdef MIPI_RX_HEADER_ECC_CHECK_EN
    send(h, 3, 0, 3'd0, 3, 1'b0);
    chk("ecc_type_hold", ptype, 3);
`else
    send(h, 3, 2, 3'd4, 0, 1'b0);
    chk("ecc_ignored_type", ptype, 4);
`endif
    // Reset in the middle of a payload
    drive(1'b1, mkhdr(2'd0, 6'h2C, 16'd40), e);
    for (int k = 0; k < 3; k++) begin
      seq++;
      h = 32'hC0DE_0000 + seq;
      drive(1'b1, h, e);
      wq.push_back('{h, 3'd4, e});
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    valid   = 1'b0;
    #1;
    chk("mid_rst_ov", ov, 0);
    chk("mid_rst_out", dout, 0);
    chk("mid_rst_type", ptype, 0);
    chk("mid_rst_pulses", {fs, fe, err}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(mkhdr(2'd0, 6'h2B, 16'd8), 3, 2, 3'd3, 0, 1'b0);
    send(mkhdr(2'd0, 6'h00, 16'd3), 0, 0, 3'd0, 1, 1'b0);

    repeat (4) @(negedge clk);
    chk("words_left", wq.size(), 0);
    chk("pulses_left", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
